// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - round-robin arbiter sharing one physical-memory port between I-cache and D-cache
module pmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic [LINE_W-1:0] i_pmem_wdata,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [CNT_W-1:0]  contention_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;   // 1: D-cache was served last
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              i_req, d_req;

    assign i_req = i_pmem_read | i_pmem_write;
    assign d_req = d_pmem_read | d_pmem_write;

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    state_d = last_d_q ? GRANT_I : GRANT_D;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (i_req) begin
                    state_d = GRANT_I;
                end else if (d_req) begin
                    state_d = GRANT_D;
                end
            end
            // A client dropping its request early ends the grant without updating fairness.
            GRANT_I: begin
                if (!i_req) begin
                    state_d = IDLE;
                end else if (pmem_resp) begin
                    state_d  = IDLE;
                    last_d_d = 1'b0;
                end
            end
            GRANT_D: begin
                if (!d_req) begin
                    state_d = IDLE;
                end else if (pmem_resp) begin
                    state_d  = IDLE;
                    last_d_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs are forced low while reset is applied, even before the state register clears.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_rdata = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_rdata = '0;
        d_pmem_resp  = 1'b0;
        if (reset_n) begin
            case (state_q)
                GRANT_I: begin
                    pmem_write   = i_pmem_write;
                    pmem_read    = i_pmem_read & ~i_pmem_write;
                    pmem_address = i_pmem_address;
                    pmem_wdata   = i_pmem_wdata;
                    i_pmem_rdata = pmem_rdata;
                    i_pmem_resp  = pmem_resp & i_req;
                end
                GRANT_D: begin
                    pmem_write   = d_pmem_write;
                    pmem_read    = d_pmem_read & ~d_pmem_write;
                    pmem_address = d_pmem_address;
                    pmem_wdata   = d_pmem_wdata;
                    d_pmem_rdata = pmem_rdata;
                    d_pmem_resp  = pmem_resp & d_req;
                end
                default: ;
            endcase
        end
    end

    assign contention_count = reset_n ? cnt_q : '0;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - directed self-checking bench for pmem_arbiter
module tb_pmem_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;
    localparam logic [LW-1:0] PAT_A5 = {16{8'hA5}};
    localparam logic [LW-1:0] PAT_3C = {16{8'h3C}};
    localparam logic [LW-1:0] PAT_W  = {8{16'hBEEF}};

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write;
    logic [AW-1:0] i_pmem_address, d_pmem_address;
    logic [LW-1:0] i_pmem_wdata, d_pmem_wdata;
    logic [LW-1:0] i_pmem_rdata, d_pmem_rdata;
    logic          i_pmem_resp, d_pmem_resp;
    logic          pmem_read, pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic [15:0]   contention_count;

    logic [LW-1:0] s_i_rdata, s_d_rdata, s_wdata;
    logic          s_i_resp, s_d_resp, s_read, s_write;
    logic [AW-1:0] s_address;
    logic [2:0]    s_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
        .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .contention_count(contention_count)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(3)) dut_sat (
        .clk(clk), .reset_n(reset_n),
        .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
        .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
        .i_pmem_rdata(s_i_rdata), .i_pmem_resp(s_i_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(s_d_rdata), .d_pmem_resp(s_d_resp),
        .pmem_read(s_read), .pmem_write(s_write),
        .pmem_address(s_address), .pmem_wdata(s_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .contention_count(s_count)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_in();
        i_pmem_read = 1'b0; i_pmem_write = 1'b0; i_pmem_address = '0; i_pmem_wdata = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
    endtask

    task automatic do_reset();
        cyc();
        reset_n = 1'b0;
        clear_in();
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_in();
        i_pmem_read = 1'b1; d_pmem_write = 1'b1; pmem_resp = 1'b1; pmem_rdata = PAT_A5;
        i_pmem_address = 16'h1111; d_pmem_address = 16'h2222;
        cyc(); cyc(); #1;
        checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL rst_pmem_read got %b want 0", pmem_read); end
        checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL rst_pmem_write got %b want 0", pmem_write); end
        checks++; if (pmem_address !== 16'h0) begin errors++; $display("FAIL rst_addr got %h want 0", pmem_address); end
        checks++; if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin errors++; $display("FAIL rst_resp got %b%b want 00", i_pmem_resp, d_pmem_resp); end
        checks++; if (i_pmem_rdata !== '0) begin errors++; $display("FAIL rst_i_rdata got %h want 0", i_pmem_rdata); end
        checks++; if (contention_count !== 16'd0) begin errors++; $display("FAIL rst_count got %0d want 0", contention_count); end
        cyc();
        reset_n = 1'b1;
        #1;
        checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin errors++; $display("FAIL post_rst_strobe got %b%b want 00", pmem_read, pmem_write); end
        checks++; if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin errors++; $display("FAIL post_rst_resp got %b%b want 00", i_pmem_resp, d_pmem_resp); end
        checks++; if (contention_count !== 16'd0) begin errors++; $display("FAIL post_rst_count got %0d want 0", contention_count); end
        clear_in();
    endtask

    task automatic test_single_read();
        do_reset();
        i_pmem_read = 1'b1; i_pmem_address = 16'h1230;
        #1;
        checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL single_req_cycle got %b want 0", pmem_read); end
        cyc(); #1;
        checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL single_pmem_read got %b want 1", pmem_read); end
        checks++; if (pmem_address !== 16'h1230) begin errors++; $display("FAIL single_addr got %h want 1230", pmem_address); end
        cyc(); cyc();
        pmem_resp = 1'b1; pmem_rdata = PAT_A5;
        #1;
        checks++; if (i_pmem_resp !== 1'b1) begin errors++; $display("FAIL single_i_resp got %b want 1", i_pmem_resp); end
        checks++; if (i_pmem_rdata !== PAT_A5) begin errors++; $display("FAIL single_i_rdata got %h want %h", i_pmem_rdata, PAT_A5); end
        checks++; if (d_pmem_resp !== 1'b0 || d_pmem_rdata !== '0) begin errors++; $display("FAIL single_d_quiet got %b %h want 0 0", d_pmem_resp, d_pmem_rdata); end
        cyc();
        i_pmem_read = 1'b0;
        #1;
        checks++; if (i_pmem_resp !== 1'b0 || pmem_read !== 1'b0) begin errors++; $display("FAIL single_idle_resp got %b%b want 00", i_pmem_resp, pmem_read); end
        clear_in();
    endtask

    task automatic test_simultaneous();
        do_reset();
        i_pmem_read = 1'b1; i_pmem_address = 16'h0100;
        d_pmem_write = 1'b1; d_pmem_address = 16'h0200; d_pmem_wdata = PAT_W;
        #1;
        checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin errors++; $display("FAIL sim_idle_strobe got %b%b want 00", pmem_read, pmem_write); end
        cyc(); #1;
        checks++; if (pmem_write !== 1'b1 || pmem_address !== 16'h0200) begin errors++; $display("FAIL sim_first_d got w=%b a=%h want w=1 a=0200", pmem_write, pmem_address); end
        checks++; if (pmem_wdata !== PAT_W) begin errors++; $display("FAIL sim_wdata got %h want %h", pmem_wdata, PAT_W); end
        checks++; if (contention_count !== 16'd1) begin errors++; $display("FAIL sim_count got %0d want 1", contention_count); end
        cyc();
        pmem_resp = 1'b1; pmem_rdata = PAT_3C;
        #1;
        checks++; if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin errors++; $display("FAIL sim_d_resp got d=%b i=%b want d=1 i=0", d_pmem_resp, i_pmem_resp); end
        checks++; if (i_pmem_rdata !== '0) begin errors++; $display("FAIL sim_i_rdata got %h want 0", i_pmem_rdata); end
        cyc();
        d_pmem_write = 1'b0; pmem_resp = 1'b0;
        #1;
        checks++; if (pmem_read !== 1'b0 || pmem_address !== 16'h0) begin errors++; $display("FAIL sim_idle got r=%b a=%h want r=0 a=0", pmem_read, pmem_address); end
        cyc(); #1;
        checks++; if (pmem_read !== 1'b1 || pmem_address !== 16'h0100) begin errors++; $display("FAIL sim_second_i got r=%b a=%h want r=1 a=0100", pmem_read, pmem_address); end
        checks++; if (contention_count !== 16'd1) begin errors++; $display("FAIL sim_count2 got %0d want 1", contention_count); end
        cyc();
        pmem_resp = 1'b1;
        #1;
        checks++; if (i_pmem_resp !== 1'b1) begin errors++; $display("FAIL sim_i_resp got %b want 1", i_pmem_resp); end
        cyc();
        clear_in();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] exp_addr [4];
        exp_addr[0] = 16'h0400; exp_addr[1] = 16'h0300; exp_addr[2] = 16'h0400; exp_addr[3] = 16'h0300;
        do_reset();
        i_pmem_read = 1'b1; i_pmem_address = 16'h0300;
        d_pmem_read = 1'b1; d_pmem_address = 16'h0400;
        for (int t = 0; t < 4; t++) begin
            #1;
            checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL b2b_idle%0d got %b want 0", t, pmem_read); end
            cyc(); #1;
            checks++; if (pmem_address !== exp_addr[t]) begin errors++; $display("FAIL b2b_grant%0d got %h want %h", t, pmem_address, exp_addr[t]); end
            cyc();
            pmem_resp = 1'b1;
            #1;
            checks++; if ({i_pmem_resp, d_pmem_resp} !== ((t % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL b2b_resp%0d got i=%b d=%b", t, i_pmem_resp, d_pmem_resp); end
            cyc();
            pmem_resp = 1'b0;
        end
        clear_in();
        #1;
        checks++; if (contention_count !== 16'd4) begin errors++; $display("FAIL b2b_count got %0d want 4", contention_count); end
    endtask

    task automatic test_late_requester();
        do_reset();
        d_pmem_read = 1'b1; d_pmem_address = 16'h0500;
        cyc(); cyc();
        i_pmem_read = 1'b1; i_pmem_address = 16'h0600;
        #1;
        checks++; if (pmem_address !== 16'h0500 || i_pmem_resp !== 1'b0) begin errors++; $display("FAIL late_hold got a=%h i=%b want a=0500 i=0", pmem_address, i_pmem_resp); end
        cyc();
        pmem_resp = 1'b1;
        #1;
        checks++; if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0 || pmem_address !== 16'h0500) begin errors++; $display("FAIL late_d_resp got d=%b i=%b a=%h", d_pmem_resp, i_pmem_resp, pmem_address); end
        cyc();
        d_pmem_read = 1'b0; pmem_resp = 1'b0;
        #1;
        checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL late_mandatory_idle got %b want 0", pmem_read); end
        cyc(); #1;
        checks++; if (pmem_read !== 1'b1 || pmem_address !== 16'h0600) begin errors++; $display("FAIL late_i_grant got r=%b a=%h want r=1 a=0600", pmem_read, pmem_address); end
        checks++; if (contention_count !== 16'd0) begin errors++; $display("FAIL late_count got %0d want 0", contention_count); end
        cyc();
        pmem_resp = 1'b1;
        cyc();
        clear_in();
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_pmem_read = 1'b1; i_pmem_address = 16'h0A00;
        d_pmem_read = 1'b1; d_pmem_address = 16'h0B00;
        cyc();
        cyc();
        pmem_resp = 1'b1;
        cyc();
        d_pmem_read = 1'b0; pmem_resp = 1'b0;
        cyc(); #1;
        checks++; if (pmem_read !== 1'b1 || contention_count !== 16'd1) begin errors++; $display("FAIL rmid_setup got r=%b c=%0d want r=1 c=1", pmem_read, contention_count); end
        reset_n = 1'b0; pmem_resp = 1'b1;
        #1;
        checks++; if (pmem_read !== 1'b0 || i_pmem_resp !== 1'b0) begin errors++; $display("FAIL rmid_rst_cycle got r=%b i=%b want 00", pmem_read, i_pmem_resp); end
        cyc();
        reset_n = 1'b1; pmem_resp = 1'b0; d_pmem_read = 1'b1;
        #1;
        checks++; if (pmem_read !== 1'b0 || contention_count !== 16'd0) begin errors++; $display("FAIL rmid_after got r=%b c=%0d want r=0 c=0", pmem_read, contention_count); end
        checks++; if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin errors++; $display("FAIL rmid_resp got i=%b d=%b want 00", i_pmem_resp, d_pmem_resp); end
        cyc(); #1;
        checks++; if (pmem_address !== 16'h0B00) begin errors++; $display("FAIL rmid_tie got %h want 0B00", pmem_address); end
        cyc();
        pmem_resp = 1'b1;
        cyc();
        clear_in();
    endtask

    task automatic test_protocol();
        do_reset();
        d_pmem_read = 1'b1; d_pmem_address = 16'h0C00;
        cyc(); cyc();
        pmem_resp = 1'b1;
        cyc();
        d_pmem_read = 1'b0; pmem_resp = 1'b0;
        i_pmem_read = 1'b1; i_pmem_write = 1'b1; i_pmem_address = 16'h0700; i_pmem_wdata = PAT_W;
        cyc(); #1;
        checks++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin errors++; $display("FAIL proto_rw got w=%b r=%b want w=1 r=0", pmem_write, pmem_read); end
        checks++; if (pmem_wdata !== PAT_W || pmem_address !== 16'h0700) begin errors++; $display("FAIL proto_rw_data got a=%h d=%h", pmem_address, pmem_wdata); end
        cyc();
        i_pmem_read = 1'b0; i_pmem_write = 1'b0; pmem_resp = 1'b1;
        #1;
        checks++; if (i_pmem_resp !== 1'b0) begin errors++; $display("FAIL proto_drop_resp got %b want 0", i_pmem_resp); end
        cyc();
        pmem_resp = 1'b0;
        i_pmem_read = 1'b1; i_pmem_address = 16'h0800;
        d_pmem_read = 1'b1; d_pmem_address = 16'h0900;
        #1;
        checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin errors++; $display("FAIL proto_idle got r=%b w=%b want 00", pmem_read, pmem_write); end
        cyc(); #1;
        checks++; if (pmem_address !== 16'h0800) begin errors++; $display("FAIL proto_last_grant got %h want 0800", pmem_address); end
        cyc();
        pmem_resp = 1'b1;
        cyc();
        clear_in();
    endtask

    task automatic test_saturation();
        do_reset();
        i_pmem_read = 1'b1; i_pmem_address = 16'h0D00;
        d_pmem_read = 1'b1; d_pmem_address = 16'h0E00;
        pmem_resp = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 12) begin
                #1;
                checks++; if (contention_count !== 16'd6 || s_count !== 3'd6) begin errors++; $display("FAIL sat_mid got %0d/%0d want 6/6", contention_count, s_count); end
            end
            cyc();
        end
        clear_in();
        #1;
        checks++; if (contention_count !== 16'd10) begin errors++; $display("FAIL sat_wide got %0d want 10", contention_count); end
        checks++; if (s_count !== 3'd7) begin errors++; $display("FAIL sat_narrow got %0d want 7", s_count); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_back_to_back();
        test_late_requester();
        test_reset_mid();
        test_protocol();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
